// File: rtl/systolic_deskew.sv
// systolic_deskew
//   Removes the column stagger from the bottom edge of the systolic array.
//   Column j of a row arrives j cycles after column 0; each column is delayed
//   so that all PORTS columns line up, and the aligned row is written into a
//   small FIFO that drains over a valid/ready interface.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   in            skewed column data, column j at in[j*DATA_WIDTH +: DATA_WIDTH]
//   in_valid      marks column 0 of a row; column j follows j cycles later
//   out           aligned row at the FIFO head (0 after reset)
//   out_valid     FIFO non-empty
//   out_ready     consumer accepts out this cycle
//   count         FIFO occupancy, 0..FIFO_DEPTH
//   overflow      sticky flag, a row was dropped because the FIFO was full
//   clr_overflow  synchronous clear of overflow (a drop in the same cycle wins)
module systolic_deskew #(
  parameter int DATA_WIDTH = 32,
  parameter int PORTS      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0]      in,
  input  logic                             in_valid,
  output logic [PORTS*DATA_WIDTH-1:0]      out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(FIFO_DEPTH):0]      count,
  output logic                             overflow,
  input  logic                             clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = PORTS * DATA_WIDTH;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [W-1:0] aligned;
  logic         vtail;

  // Column j needs PORTS-1-j stages so it lands together with the last
  // column, which is used straight from the input.
  for (genvar j = 0; j < PORTS; j++) begin : g_col
    if (j == PORTS - 1) begin : g_direct
      assign aligned[j*DATA_WIDTH +: DATA_WIDTH] = in[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_delay
      localparam int LEN = PORTS - 1 - j;
      logic [DATA_WIDTH-1:0] sr [LEN];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < LEN; k++) sr[k] <= '0;
        end else begin
          sr[0] <= in[j*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < LEN; k++) sr[k] <= sr[k-1];
        end
      end

      assign aligned[j*DATA_WIDTH +: DATA_WIDTH] = sr[LEN-1];
    end
  end

  // in_valid travels alongside column 0, so it sees the same PORTS-1 stages.
  if (PORTS == 1) begin : g_vnone
    assign vtail = in_valid;
  end else begin : g_vpipe
    logic [PORTS-2:0] vp;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vp <= '0;
      end else begin
        vp[0] <= in_valid;
        for (int k = 1; k <= PORTS - 2; k++) vp[k] <= vp[k-1];
      end
    end

    assign vtail = vp[PORTS-2];
  end

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          ovf;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (cnt == DEPTH_C);
  assign pop  = (cnt != '0) && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = vtail && (!full || pop);
  assign drop = vtail && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= aligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop)              ovf <= 1'b1;
      else if (clr_overflow) ovf <= 1'b0;
    end
  end

  assign out       = mem[rd_ptr];
  assign out_valid = (cnt != '0);
  assign count     = cnt;
  assign overflow  = ovf;

endmodule

// File: tb/tb_systolic_deskew.sv
// tb_systolic_deskew
//   Drives a PORTS=8 and a PORTS=1 instance with the same control stream.
//   A row is identified by the cycle its column 0 was presented; its aligned
//   word is simply the row vector chosen for that cycle. The reference model
//   holds whole rows in queues and applies push/pop/drop rules per edge.
module tb_systolic_deskew;

  localparam int DW    = 32;
  localparam int P8    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, in_valid, out_ready, clr_overflow;
  logic [P8*DW-1:0] in8, out8;
  logic [DW-1:0]   in1, out1;
  logic            ov8, ov1, of8, of1;
  logic [3:0]      cnt8, cnt1;

  systolic_deskew #(.DATA_WIDTH(DW), .PORTS(P8), .FIFO_DEPTH(DEPTH)) dut8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .in_valid(in_valid), .out(out8),
    .out_valid(ov8), .out_ready(out_ready), .count(cnt8), .overflow(of8),
    .clr_overflow(clr_overflow));

  systolic_deskew #(.DATA_WIDTH(DW), .PORTS(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .in_valid(in_valid), .out(out1),
    .out_valid(ov1), .out_ready(out_ready), .count(cnt1), .overflow(of1),
    .clr_overflow(clr_overflow));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rst_cyc = 0;

  bit             hist_v [0:4095];
  logic [255:0]   hist_d [0:4095];
  logic [255:0]   mq8[$];
  logic [255:0]   mq1[$];
  bit             movf [2];

  logic           ev [2];
  logic [3:0]     ec [2];
  logic [255:0]   eo [2];
  logic           ef [2];
  logic           av [2];
  logic [3:0]     ac [2];
  logic [255:0]   ao [2];
  logic           af [2];

  assign av[0] = ov8;  assign av[1] = ov1;
  assign ac[0] = cnt8; assign ac[1] = cnt1;
  assign ao[0] = out8; assign ao[1] = {224'b0, out1};
  assign af[0] = of8;  assign af[1] = of1;

  function automatic logic [255:0] rand_row();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic refresh_expect();
    ev[0] = mq8.size() > 0; ec[0] = 4'(mq8.size()); ef[0] = movf[0];
    eo[0] = (mq8.size() > 0) ? mq8[0] : '0;
    ev[1] = mq1.size() > 0; ec[1] = 4'(mq1.size()); ef[1] = movf[1];
    eo[1] = (mq1.size() > 0) ? mq1[0] : '0;
  endtask

  task automatic model_reset();
    mq8.delete(); mq1.delete();
    movf[0] = 1'b0; movf[1] = 1'b0;
    rst_cyc = cyc;
    refresh_expect();
  endtask

  // One edge: a row started at cycle s is ready to enter the FIFO at s+PORTS-1.
  task automatic model_edge(input bit rdy, input bit clr);
    for (int k = 0; k < 2; k++) begin
      int src = cyc - ((k == 0) ? P8 - 1 : 0);
      bit psh = (src >= rst_cyc) && hist_v[src];
      int sz = (k == 0) ? mq8.size() : mq1.size();
      bit pp = (sz > 0) && rdy;
      bit drp = psh && (sz == DEPTH) && !pp;
      logic [255:0] w = '0;
      if (psh) w = (k == 0) ? hist_d[src] : {224'b0, hist_d[src][31:0]};
      if (k == 0) begin
        if (pp) void'(mq8.pop_front());
        if (psh && !drp) mq8.push_back(w);
      end else begin
        if (pp) void'(mq1.pop_front());
        if (psh && !drp) mq1.push_back(w);
      end
      if (drp) movf[k] = 1'b1;
      else if (clr) movf[k] = 1'b0;
    end
    refresh_expect();
  endtask

  task automatic step(input bit iv, input bit rdy, input bit clr, input logic [255:0] row);
    hist_v[cyc] = iv;
    hist_d[cyc] = row;
    for (int j = 0; j < P8; j++) begin
      if (cyc - j >= 0) in8[j*32 +: 32] = hist_d[cyc-j][j*32 +: 32];
      else              in8[j*32 +: 32] = '0;
    end
    in1 = row[31:0];
    in_valid = iv; out_ready = rdy; clr_overflow = clr;
    @(posedge clk);
    model_edge(rdy, clr);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
    rst_n = 1'b0;
    #2;
  endtask

  task automatic release_reset();
    @(posedge clk);
    hist_v[cyc] = 1'b0;
    cyc++;
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (ov8 !== 1'b0 || cnt8 !== 4'd0 || of8 !== 1'b0 || out8 !== '0) begin
      n_bad++; $display("FAIL reset_p8 got v=%0b c=%0d f=%0b out=%h exp all zero", ov8, cnt8, of8, out8);
    end
    n_cmp++; if (ov1 !== 1'b0 || cnt1 !== 4'd0 || of1 !== 1'b0 || out1 !== '0) begin
      n_bad++; $display("FAIL reset_p1 got v=%0b c=%0d f=%0b out=%h exp all zero", ov1, cnt1, of1, out1);
    end
    release_reset();
  endtask

  task automatic test_single_row();
    logic [255:0] row;
    for (int j = 0; j < 8; j++) row[j*32 +: 32] = 32'(j + 1);
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 1'b1, 1'b0, (i == 0) ? row : rand_row());
      n_cmp++; if (ov8 !== (i == 7) || (i == 7 && out8 !== row)) begin
        n_bad++; $display("FAIL single_p8 i=%0d got v=%0b out=%h exp v=%0b out=%h", i, ov8, out8, (i == 7), row);
      end
      n_cmp++; if (ov1 !== (i == 0) || (i == 0 && out1 !== 32'd1)) begin
        n_bad++; $display("FAIL single_p1 i=%0d got v=%0b out=%h exp v=%0b out=1", i, ov1, out1, (i == 0));
      end
    end
  endtask

  task automatic test_stream();
    logic [255:0] row, exp;
    for (int i = 0; i < 26; i++) begin
      for (int j = 0; j < 8; j++) row[j*32 +: 32] = 32'(16 * i + j);
      step(i < 16, 1'b1, 1'b0, (i < 16) ? row : rand_row());
      for (int j = 0; j < 8; j++) exp[j*32 +: 32] = 32'(16 * (i - 7) + j);
      n_cmp++; if (ov8 !== (i >= 7 && i < 23) || (ov8 && out8 !== exp) || cnt8 > 4'd1) begin
        n_bad++; $display("FAIL stream_p8 i=%0d got v=%0b c=%0d out=%h exp out=%h", i, ov8, cnt8, out8, exp);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (av[k] !== ev[k] || ac[k] !== ec[k] || af[k] !== ef[k] || (ev[k] && ao[k] !== eo[k])) begin
          n_bad++; $display("FAIL stream_model dut%0d cyc=%0d got v=%0b c=%0d f=%0b out=%h exp v=%0b c=%0d f=%0b out=%h",
                            k, cyc, av[k], ac[k], af[k], ao[k], ev[k], ec[k], ef[k], eo[k]);
        end
      end
    end
  endtask

  task automatic test_fill_overflow();
    int start = cyc;
    int n8 = 0;
    for (int i = 0; i < 19; i++) step(i < 9, 1'b0, 1'b0, rand_row());
    n_cmp++; if (cnt8 !== 4'd8 || of8 !== 1'b1 || out8 !== hist_d[start]) begin
      n_bad++; $display("FAIL fill_p8 got c=%0d f=%0b out=%h exp c=8 f=1 out=%h", cnt8, of8, out8, hist_d[start]);
    end
    n_cmp++; if (cnt1 !== 4'd8 || of1 !== 1'b1 || out1 !== hist_d[start][31:0]) begin
      n_bad++; $display("FAIL fill_p1 got c=%0d f=%0b out=%h exp c=8 f=1 out=%h", cnt1, of1, out1, hist_d[start][31:0]);
    end
    for (int i = 0; i < 10; i++) begin
      if (ov8) begin
        n_cmp++; if (out8 !== hist_d[start + n8]) begin
          n_bad++; $display("FAIL drain_p8 row=%0d got %h exp %h", n8, out8, hist_d[start + n8]);
        end
        n8++;
      end
      step(1'b0, 1'b1, 1'b0, rand_row());
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (av[k] !== ev[k] || ac[k] !== ec[k] || af[k] !== ef[k] || (ev[k] && ao[k] !== eo[k])) begin
          n_bad++; $display("FAIL drain_model dut%0d cyc=%0d got v=%0b c=%0d f=%0b out=%h exp v=%0b c=%0d f=%0b out=%h",
                            k, cyc, av[k], ac[k], af[k], ao[k], ev[k], ec[k], ef[k], eo[k]);
        end
      end
    end
    n_cmp++; if (n8 !== 8) begin
      n_bad++; $display("FAIL drain_rows got %0d exp 8", n8);
    end
  endtask

  task automatic test_full_pushpop();
    int order[$];
    step(1'b0, 1'b0, 1'b1, rand_row());
    n_cmp++; if (of8 !== 1'b0 || of1 !== 1'b0) begin
      n_bad++; $display("FAIL clr_ovf got p8=%0b p1=%0b exp 0 0", of8, of1);
    end
    for (int i = 0; i < 16; i++) begin
      if (i < 8) order.push_back(cyc);
      step(i < 8, 1'b0, 1'b0, rand_row());
    end
    for (int i = 0; i < 7; i++) begin
      order.push_back(cyc);
      step(1'b1, 1'b0, 1'b0, rand_row());
    end
    for (int i = 0; i < 36; i++) begin
      bit iv = (i < 20);
      if (ov8) begin
        n_cmp++; if (order.size() == 0 || out8 !== hist_d[order[0]]) begin
          n_bad++; $display("FAIL wrap_order_p8 i=%0d got %h", i, out8);
        end
        if (order.size() > 0) void'(order.pop_front());
      end
      if (iv) order.push_back(cyc);
      step(iv, 1'b1, 1'b0, rand_row());
      if (i < 20) begin
        n_cmp++; if (cnt8 !== 4'd8 || of8 !== 1'b0) begin
          n_bad++; $display("FAIL full_pushpop_p8 i=%0d got c=%0d f=%0b exp c=8 f=0", i, cnt8, of8);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (av[k] !== ev[k] || ac[k] !== ec[k] || af[k] !== ef[k] || (ev[k] && ao[k] !== eo[k])) begin
          n_bad++; $display("FAIL pushpop_model dut%0d cyc=%0d got v=%0b c=%0d f=%0b out=%h exp v=%0b c=%0d f=%0b out=%h",
                            k, cyc, av[k], ac[k], af[k], ao[k], ev[k], ec[k], ef[k], eo[k]);
        end
      end
    end
    n_cmp++; if (order.size() !== 0 || ov8 !== 1'b0) begin
      n_bad++; $display("FAIL wrap_left_p8 got %0d rows pending v=%0b exp 0", order.size(), ov8);
    end
  endtask

  task automatic test_reset_midrow();
    logic [255:0] row = rand_row();
    for (int i = 0; i < 3; i++) step(i == 0, 1'b1, 1'b0, rand_row());
    apply_reset();
    n_cmp++; if (ov8 !== 1'b0 || cnt8 !== 4'd0 || ov1 !== 1'b0 || cnt1 !== 4'd0) begin
      n_bad++; $display("FAIL midrow_reset got v8=%0b c8=%0d v1=%0b c1=%0d exp 0", ov8, cnt8, ov1, cnt1);
    end
    release_reset();
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 1'b1, 1'b0, (i == 0) ? row : rand_row());
      n_cmp++; if (ov8 !== (i == 7) || (i == 7 && out8 !== row)) begin
        n_bad++; $display("FAIL post_reset_row i=%0d got v=%0b out=%h exp v=%0b out=%h", i, ov8, out8, (i == 7), row);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (av[k] !== ev[k] || ac[k] !== ec[k] || af[k] !== ef[k] || (ev[k] && ao[k] !== eo[k])) begin
          n_bad++; $display("FAIL reset_model dut%0d cyc=%0d got v=%0b c=%0d f=%0b out=%h exp v=%0b c=%0d f=%0b out=%h",
                            k, cyc, av[k], ac[k], af[k], ao[k], ev[k], ec[k], ef[k], eo[k]);
        end
      end
    end
  endtask

  task automatic test_clr_vs_drop();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, rand_row());
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, rand_row());
    step(1'b0, 1'b0, 1'b1, rand_row());
    n_cmp++; if (of8 !== 1'b1) begin
      n_bad++; $display("FAIL clr_and_drop_p8 got %0b exp 1", of8);
    end
    step(1'b0, 1'b0, 1'b1, rand_row());
    n_cmp++; if (of8 !== 1'b0) begin
      n_bad++; $display("FAIL clr_alone_p8 got %0b exp 0", of8);
    end
    step(1'b1, 1'b0, 1'b1, rand_row());
    n_cmp++; if (of1 !== 1'b1) begin
      n_bad++; $display("FAIL clr_and_drop_p1 got %0b exp 1", of1);
    end
    step(1'b0, 1'b0, 1'b1, rand_row());
    n_cmp++; if (of1 !== 1'b0) begin
      n_bad++; $display("FAIL clr_alone_p1 got %0b exp 0", of1);
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (av[k] !== ev[k] || ac[k] !== ec[k] || af[k] !== ef[k] || (ev[k] && ao[k] !== eo[k])) begin
        n_bad++; $display("FAIL clr_model dut%0d cyc=%0d got v=%0b c=%0d f=%0b out=%h exp v=%0b c=%0d f=%0b out=%h",
                          k, cyc, av[k], ac[k], af[k], ao[k], ev[k], ec[k], ef[k], eo[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rand_row());
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (av[k] !== ev[k] || ac[k] !== ec[k] || af[k] !== ef[k] || (ev[k] && ao[k] !== eo[k])) begin
          n_bad++; $display("FAIL random_model dut%0d cyc=%0d got v=%0b c=%0d f=%0b out=%h exp v=%0b c=%0d f=%0b out=%h",
                            k, cyc, av[k], ac[k], af[k], ao[k], ev[k], ec[k], ef[k], eo[k]);
        end
      end
    end
  endtask

  initial begin
    in8 = '0; in1 = '0;
    test_reset();
    test_single_row();
    test_stream();
    test_fill_overflow();
    test_full_pushpop();
    test_reset_midrow();
    test_clr_vs_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
